// File: rtl/control_unit_pkg.sv
// control_unit_pkg: shared types and encodings for the multicycle control unit.
//   - state_t     : FSM state enumeration
//   - OP_*        : opcode field values
//   - PC_*        : pcSrcSelect encodings
//   - WD_*        : regFileWriteDataSelect encodings
package control_unit_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_ALU   = 4'b0000;
  localparam logic [3:0] OP_ALUI  = 4'b0001;
  localparam logic [3:0] OP_SHRO  = 4'b0010;
  localparam logic [3:0] OP_LOAD  = 4'b0011;
  localparam logic [3:0] OP_STORE = 4'b0100;
  localparam logic [3:0] OP_JMP   = 4'b0101;
  localparam logic [3:0] OP_BZ    = 4'b0110;
  localparam logic [3:0] OP_BC    = 4'b0111;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_JMP = 2'b01;
  localparam logic [1:0] PC_BR  = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_SHR = 2'b10;

endpackage

// File: rtl/control_unit_mem_wait_timer.sv
// cu_mem_wait_timer: counts consecutive MEM cycles without memReady.
// Only instantiated when CU_MEM_WAIT_EN is defined.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_in_mem     : FSM is in MEM this cycle
//   i_ready      : memory completion strobe
//   o_expire     : this cycle is the MEM_TIMEOUT-th consecutive missed cycle
module cu_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in_mem,
  input  logic i_ready,
  output logic o_expire
);

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  logic [CW-1:0] r_cnt;

  // r_cnt = number of earlier missed cycles in the current MEM visit
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_in_mem || i_ready) r_cnt <= '0;
    else                               r_cnt <= r_cnt + 1'b1;
  end

  assign o_expire = i_in_mem && !i_ready && (r_cnt == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/control_unit.sv
// control_unit: Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB/HALT for a
// simple multicycle datapath. Outputs decode from state plus opcode/func.
// Optional macro CU_MEM_WAIT_EN: MEM waits for memReady with a MEM_TIMEOUT
// cycle watchdog that halts with fault=1. Without it MEM lasts one cycle,
// memReady is ignored and fault is 0.
// Ports: clk, rst (sync, active high); opcode, func, C, Z, memReady in;
//   pcEn, pcSrcSelect, irEn, CEn, ZEn, regWrite, regFileReadRegister2Select,
//   ALUBInputSelect, ALUOperation, regFileWriteDataSelect, SHROOperation,
//   DMMemWrite, DMMemRead, halted, fault out.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic [2:0] func,
  input  logic       C,
  input  logic       Z,
  input  logic       memReady,
  output logic       pcEn,
  output logic [1:0] pcSrcSelect,
  output logic       irEn,
  output logic       CEn,
  output logic       ZEn,
  output logic       regWrite,
  output logic       regFileReadRegister2Select,
  output logic       ALUBInputSelect,
  output logic [2:0] ALUOperation,
  output logic [1:0] regFileWriteDataSelect,
  output logic [1:0] SHROOperation,
  output logic       DMMemWrite,
  output logic       DMMemRead,
  output logic       halted,
  output logic       fault
);

  state_t r_state, w_next;
  logic   w_expire;

`ifdef CU_MEM_WAIT_EN
  logic r_fault;

  cu_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_in_mem (r_state == S_MEM),
    .i_ready  (memReady),
    .o_expire (w_expire)
  );

  // Sticky until reset; the FSM sits in HALT alongside it.
  always_ff @(posedge clk) begin
    if (rst)           r_fault <= 1'b0;
    else if (w_expire) r_fault <= 1'b1;
  end

  assign fault = r_fault && !rst;
`else
  logic w_unused;
  assign w_unused = memReady ^ (MEM_TIMEOUT != 0);
  assign w_expire = 1'b0;
  assign fault    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next                     = r_state;
    pcEn                       = 1'b0;
    pcSrcSelect                = PC_INC;
    irEn                       = 1'b0;
    CEn                        = 1'b0;
    ZEn                        = 1'b0;
    regWrite                   = 1'b0;
    regFileReadRegister2Select = 1'b1;
    ALUBInputSelect            = 1'b0;
    ALUOperation               = 3'b000;
    regFileWriteDataSelect     = WD_ALU;
    SHROOperation              = 2'b00;
    DMMemWrite                 = 1'b0;
    DMMemRead                  = 1'b0;
    halted                     = 1'b0;

    case (r_state)
      S_FETCH: begin
        pcEn   = 1'b1;
        irEn   = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: w_next = (opcode == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        w_next = S_FETCH;
        case (opcode)
          OP_ALU, OP_ALUI: begin
            ALUOperation    = func;
            ALUBInputSelect = (opcode == OP_ALUI);
            CEn             = 1'b1;
            ZEn             = 1'b1;
            w_next          = S_WB;
          end
          OP_SHRO: begin
            SHROOperation = func[1:0];
            CEn           = 1'b1;
            ZEn           = 1'b1;
            w_next        = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            ALUOperation    = 3'b000;
            ALUBInputSelect = 1'b1;
            w_next          = S_MEM;
          end
          OP_JMP: begin
            pcEn        = 1'b1;
            pcSrcSelect = PC_JMP;
          end
          OP_BZ: if (Z) begin
            pcEn        = 1'b1;
            pcSrcSelect = PC_BR;
          end
          OP_BC: if (C) begin
            pcEn        = 1'b1;
            pcSrcSelect = PC_BR;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (opcode == OP_LOAD) DMMemRead = 1'b1;
        else begin
          DMMemWrite                 = 1'b1;
          regFileReadRegister2Select = 1'b0;
        end
`ifdef CU_MEM_WAIT_EN
        if (memReady)      w_next = (opcode == OP_LOAD) ? S_WB : S_FETCH;
        else if (w_expire) w_next = S_HALT;
`else
        w_next = (opcode == OP_LOAD) ? S_WB : S_FETCH;
`endif
      end
      S_WB: begin
        regWrite = 1'b1;
        w_next   = S_FETCH;
        // Keep the EXEC selects so the result stays valid while written.
        case (opcode)
          OP_ALU, OP_ALUI: begin
            ALUOperation           = func;
            ALUBInputSelect        = (opcode == OP_ALUI);
            regFileWriteDataSelect = WD_ALU;
          end
          OP_SHRO: begin
            SHROOperation          = func[1:0];
            regFileWriteDataSelect = WD_SHR;
          end
          default: regFileWriteDataSelect = WD_MEM;
        endcase
      end
      S_HALT: begin
        halted = 1'b1;
        w_next = S_HALT;
      end
      default: w_next = S_FETCH;
    endcase

    // Reset blanks every output in the same cycle, whatever the state.
    if (rst) begin
      pcEn                       = 1'b0;
      pcSrcSelect                = 2'b00;
      irEn                       = 1'b0;
      CEn                        = 1'b0;
      ZEn                        = 1'b0;
      regWrite                   = 1'b0;
      regFileReadRegister2Select = 1'b0;
      ALUBInputSelect            = 1'b0;
      ALUOperation               = 3'b000;
      regFileWriteDataSelect     = 2'b00;
      SHROOperation              = 2'b00;
      DMMemWrite                 = 1'b0;
      DMMemRead                  = 1'b0;
      halted                     = 1'b0;
    end
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max MEM wait cycles before fault (used only with CU_MEM_WAIT_EN).
REQ-002 SHALL have ports, one per line, clock and reset first:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  4  opcode field of the latched instruction.
- func  in  3  function field (ALU op / shift op).
- C  in  1  registered carry flag from the datapath.
- Z  in  1  registered zero flag from the datapath.
- memReady  in  1  data-memory completion strobe.
- pcEn  out  1  PC load enable.
- pcSrcSelect  out  2  PC source: 00 PC+1, 01 jump target, 10 branch target.
- irEn  out  1  instruction register load enable.
- CEn, ZEn  out  1 each  flag register enables.
- regWrite  out  1  register file write enable.
- regFileReadRegister2Select  out  1  1 = rt field, 0 = rd field (store data).
- ALUBInputSelect  out  1  0 = register, 1 = immediate.
- ALUOperation  out  3  ALU operation code.
- regFileWriteDataSelect  out  2  00 ALU, 01 memory, 10 shifter.
- SHROOperation  out  2  shift/rotate operation code.
- DMMemWrite, DMMemRead  out  1 each  data memory strobes.
- halted  out  1  FSM in HALT.
- fault  out  1  memory timeout occurred.

Function
REQ-003 SHALL be a Moore FSM with states FETCH, DECODE, EXEC, MEM, WB, HALT; outputs decode from state plus opcode/func.
REQ-004 FETCH SHALL assert pcEn=1, pcSrcSelect=00, irEn=1, then go to DECODE.
REQ-005 DECODE SHALL assert no enables and go to HALT if opcode=1111, else EXEC.
REQ-006 Opcode map: 0000 ALU reg, 0001 ALU imm, 0010 SHRO, 0011 LOAD, 0100 STORE, 0101 JMP, 0110 BZ, 0111 BC, 1111 HALT; all others NOP (EXEC -> FETCH, no enables).
REQ-007 EXEC for ALU reg/imm SHALL drive ALUOperation=func, ALUBInputSelect=0/1, CEn=ZEn=1, then go to WB.
REQ-008 EXEC for SHRO SHALL drive SHROOperation=func[1:0], CEn=ZEn=1, then go to WB.
REQ-009 EXEC for LOAD/STORE SHALL drive ALUOperation=000, ALUBInputSelect=1 (address add), then go to MEM.
REQ-010 MEM SHALL assert DMMemRead (LOAD, then WB) or DMMemWrite with regFileReadRegister2Select=0 (STORE, then FETCH).
REQ-011 WB SHALL assert regWrite=1 with regFileWriteDataSelect 00 (ALU), 10 (SHRO) or 01 (LOAD), hold ALU/SHRO selects from EXEC, then go to FETCH.
REQ-012 EXEC for JMP SHALL assert pcEn=1, pcSrcSelect=01; BZ/BC SHALL do so with pcSrcSelect=10 only if Z=1 / C=1 sampled that cycle; then FETCH.
REQ-013 Cycles per instruction SHALL be: branch/jump/NOP 3, ALU/SHRO/STORE 4, LOAD 5 (without wait extension).
REQ-014 Outside the listed assertions every output SHALL be 0; regFileReadRegister2Select SHALL default to 1.
REQ-015 HALT SHALL assert halted=1, all enables 0, and remain until rst.
REQ-016 DMMemRead and DMMemWrite SHALL never be asserted in the same cycle.

Reset
REQ-017 rst=1 SHALL force state FETCH on the next edge and all outputs (halted, fault included) to 0 while rst is high, overriding any state including mid-MEM and HALT.
REQ-018 First FETCH outputs SHALL appear in the first cycle after rst deasserts.

Configuration
REQ-019 Macro CU_MEM_WAIT_EN defined: MEM SHALL hold its strobe until memReady=1, then advance; a counter SHALL move to HALT with fault=1 if memReady is absent for MEM_TIMEOUT consecutive MEM cycles; memReady in the entry cycle advances with zero wait.
REQ-020 CU_MEM_WAIT_EN undefined: MEM SHALL last exactly one cycle, memReady SHALL be ignored, fault SHALL be constant 0.

Structure
REQ-021 Package control_unit_pkg SHALL hold the state enum, opcode constants, and pcSrcSelect / regFileWriteDataSelect encodings.
REQ-022 Wait counter SHALL be sub-module cu_mem_wait_timer, instantiated only under CU_MEM_WAIT_EN.

Verification
REQ-023 ALU reg, opcode=0000 func=010 -> FETCH,DECODE,EXEC(ALUOperation=010,CEn=ZEn=1),WB(regWrite=1,sel=00); 4 cycles.
REQ-024 LOAD opcode=0011 -> DMMemRead=1 in cycle 4, regWrite=1 sel=01 in cycle 5; STORE 0100 -> DMMemWrite=1, Reg2Select=0, back to FETCH cycle 5.
REQ-025 BZ with Z=0 -> pcEn=0 in EXEC; Z=1 -> pcEn=1, pcSrcSelect=10; JMP -> pcSrcSelect=01.
REQ-026 opcode=1111 -> halted=1 from cycle 3, unaffected by opcode changes; rst pulse -> FETCH next cycle, halted=0.
REQ-027 CU_MEM_WAIT_EN: memReady after 3 cycles -> DMMemRead high 4 cycles; memReady never -> fault=1, HALT after 15 cycles.
REQ-028 rst asserted during MEM -> DMMemRead=0 same cycle, FETCH next cycle.
